// File: rtl/ab_input_debounce.sv
// Two-channel synchroniser + debouncer that feeds the a/b control FSM.
// Each channel produces a clean level and a registered rise pulse; aborted qualifications are counted.
module ab_input_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int CNT_W       = 3
) (
  input  logic       clk_amisha,
  input  logic       reset_amisha,
  input  logic       a_raw_amisha,
  input  logic       b_raw_amisha,
  input  logic       glitch_clr_amisha,
  output logic       a_amisha,
  output logic       b_amisha,
  output logic       a_rise_amisha,
  output logic       b_rise_amisha,
  output logic [7:0] glitch_cnt_amisha
);

  typedef enum logic [1:0] {
    ST_LOW,
    ST_RISE_CHK,
    ST_HIGH,
    ST_FALL_CHK
  } db_state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               DB_ONE   = (DB_CYCLES == 1);

  // Channel index 0 is A, index 1 is B.
  logic [1:0]             raw;
  logic [1:0]             s;
  logic [1:0]             level;
  logic [1:0]             abort;
  logic [1:0]             rise_q, rise_d;
  logic [SYNC_STAGES-1:0] sync_q  [2];
  logic [SYNC_STAGES-1:0] sync_d  [2];
  db_state_e              state_q [2];
  db_state_e              state_d [2];
  logic [CNT_W-1:0]       cnt_q   [2];
  logic [CNT_W-1:0]       cnt_d   [2];
  logic [7:0]             glitch_q, glitch_d;
  logic [8:0]             glitch_sum;

  assign raw = {b_raw_amisha, a_raw_amisha};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
      s[i]      = sync_q[i][SYNC_STAGES-1];
    end
  end

  // State register: reset has priority over every other input.
  // NOTE: sequential state uses <= so every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      // NOTE: the small per-channel arrays are plain flops, so resetting them costs nothing and keeps outputs defined.
      for (int i = 0; i < 2; i++) begin
        sync_q[i]  <= '0;
        state_q[i] <= ST_LOW;
        cnt_q[i]   <= '0;
      end
      rise_q   <= '0;
      glitch_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i]  <= sync_d[i];
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      rise_q   <= rise_d;
      glitch_q <= glitch_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      abort[i]   = 1'b0;
      unique case (state_q[i])
        ST_LOW: begin
          if (s[i]) begin
            state_d[i] = DB_ONE ? ST_HIGH : ST_RISE_CHK;
            cnt_d[i]   = DB_ONE ? '0 : CNT_ONE;
          end
        end
        ST_RISE_CHK: begin
          if (!s[i]) begin
            state_d[i] = ST_LOW;
            cnt_d[i]   = '0;
            abort[i]   = 1'b1;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = ST_HIGH;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!s[i]) begin
            state_d[i] = DB_ONE ? ST_LOW : ST_FALL_CHK;
            cnt_d[i]   = DB_ONE ? '0 : CNT_ONE;
          end
        end
        ST_FALL_CHK: begin
          if (s[i]) begin
            state_d[i] = ST_HIGH;
            cnt_d[i]   = '0;
            abort[i]   = 1'b1;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = ST_LOW;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_LOW;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Outputs: level decodes the state register only; the pulse flags entry into HIGH from the low side.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      level[i]  = (state_q[i] == ST_HIGH) || (state_q[i] == ST_FALL_CHK);
      rise_d[i] = (state_d[i] == ST_HIGH) && !level[i];
    end
  end

  // Saturating glitch counter; clear beats a concurrent abort.
  always_comb begin
    glitch_sum = {1'b0, glitch_q} + 9'(abort[0]) + 9'(abort[1]);
    if (glitch_clr_amisha) begin
      glitch_d = '0;
    end else if (glitch_sum[8]) begin
      glitch_d = 8'hFF;
    end else begin
      glitch_d = glitch_sum[7:0];
    end
  end

  assign a_amisha          = level[0];
  assign b_amisha          = level[1];
  assign a_rise_amisha     = rise_q[0];
  assign b_rise_amisha     = rise_q[1];
  assign glitch_cnt_amisha = glitch_q;

endmodule

// File: tb/tb_ab_input_debounce.sv
// Directed bench for ab_input_debounce: default build plus a DB_CYCLES=1 / SYNC_STAGES=3 build.
module tb_ab_input_debounce;

  logic       clk = 1'b0;
  logic       reset, a_raw, b_raw, clr;
  logic       a, b, ar, br;
  logic [7:0] gc;
  logic       c_raw, z_raw;
  logic       a6, b6, ar6, br6;
  logic [7:0] gc6;

  int vectors    = 0;
  int miscompares = 0;
  int exp_glitch = 0;

  always #5 clk = ~clk;

  ab_input_debounce u_dut (
    .clk_amisha        (clk),
    .reset_amisha      (reset),
    .a_raw_amisha      (a_raw),
    .b_raw_amisha      (b_raw),
    .glitch_clr_amisha (clr),
    .a_amisha          (a),
    .b_amisha          (b),
    .a_rise_amisha     (ar),
    .b_rise_amisha     (br),
    .glitch_cnt_amisha (gc)
  );

  ab_input_debounce #(.SYNC_STAGES(3), .DB_CYCLES(1), .CNT_W(1)) u_dut6 (
    .clk_amisha        (clk),
    .reset_amisha      (reset),
    .a_raw_amisha      (c_raw),
    .b_raw_amisha      (z_raw),
    .glitch_clr_amisha (clr),
    .a_amisha          (a6),
    .b_amisha          (b6),
    .a_rise_amisha     (ar6),
    .b_rise_amisha     (br6),
    .glitch_cnt_amisha (gc6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One abort per selected channel: a one-cycle raw high, then low; abort lands on the 4th edge.
  task automatic bounce(input logic do_a, input logic do_b, input logic clr_on_abort);
    a_raw = do_a;
    b_raw = do_b;
    tick();
    a_raw = 1'b0;
    b_raw = 1'b0;
    tick();
    tick();
    clr = clr_on_abort;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    logic exp_lvl, exp_rise;
    reset = 1'b1; a_raw = 1'b1; b_raw = 1'b1; c_raw = 1'b0; z_raw = 1'b0; clr = 1'b0;
    tick();
    tick();
    vectors++;
    if ({a, b, ar, br} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b exp=0000", {a, b, ar, br});
    end
    vectors++;
    if (gc !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_glitch got=%0d exp=0", gc);
    end
    vectors++;
    if ({a6, b6, ar6, br6, gc6} !== 12'd0) begin
      miscompares++;
      $display("FAIL reset_dut6 got=%h exp=0", {a6, b6, ar6, br6, gc6});
    end
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp_lvl  = (i >= 6);
      exp_rise = (i == 6);
      vectors++;
      if ({a, b, ar, br} !== {exp_lvl, exp_lvl, exp_rise, exp_rise}) begin
        miscompares++;
        $display("FAIL release_edge%0d got=%b exp=%b", i, {a, b, ar, br},
                 {exp_lvl, exp_lvl, exp_rise, exp_rise});
      end
    end
    a_raw = 1'b0;
    b_raw = 1'b0;
    for (int i = 1; i <= 8; i++) tick();
    vectors++;
    if ({a, b, ar, br} !== 4'b0000) begin
      miscompares++;
      $display("FAIL release_settle_low got=%b exp=0000", {a, b, ar, br});
    end
  endtask

  task automatic test_clean_a();
    logic exp_lvl, exp_rise;
    a_raw = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_lvl  = (i >= 6);
      exp_rise = (i == 6);
      vectors++;
      if ({a, ar, b, br} !== {exp_lvl, exp_rise, 2'b00}) begin
        miscompares++;
        $display("FAIL clean_rise_edge%0d got=%b exp=%b", i, {a, ar, b, br}, {exp_lvl, exp_rise, 2'b00});
      end
    end
    a_raw = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_lvl = (i < 6);
      vectors++;
      if ({a, ar} !== {exp_lvl, 1'b0}) begin
        miscompares++;
        $display("FAIL clean_fall_edge%0d got=%b exp=%b", i, {a, ar}, {exp_lvl, 1'b0});
      end
    end
    vectors++;
    if (gc !== 8'(exp_glitch)) begin
      miscompares++;
      $display("FAIL clean_glitch got=%0d exp=%0d", gc, exp_glitch);
    end
  endtask

  // Raw A: 1,1,0 then 1 for ten cycles. Abort on edge 5, qualification on edge 9.
  task automatic test_bounce();
    logic exp_lvl, exp_rise;
    int   exp_g;
    for (int k = 1; k <= 13; k++) begin
      a_raw = (k == 3) ? 1'b0 : 1'b1;
      tick();
      exp_lvl  = (k >= 9);
      exp_rise = (k == 9);
      exp_g    = exp_glitch + ((k >= 5) ? 1 : 0);
      vectors++;
      if ({a, ar} !== {exp_lvl, exp_rise} || gc !== 8'(exp_g)) begin
        miscompares++;
        $display("FAIL bounce_edge%0d got a/rise=%b cnt=%0d exp a/rise=%b cnt=%0d",
                 k, {a, ar}, gc, {exp_lvl, exp_rise}, exp_g);
      end
    end
    exp_glitch += 1;
    a_raw = 1'b0;
    for (int i = 1; i <= 8; i++) tick();
    vectors++;
    if ({a, ar} !== 2'b00 || gc !== 8'(exp_glitch)) begin
      miscompares++;
      $display("FAIL bounce_settle got a/rise=%b cnt=%0d exp a/rise=00 cnt=%0d", {a, ar}, gc, exp_glitch);
    end
  endtask

  task automatic test_simultaneous();
    a_raw = 1'b1; b_raw = 1'b1;
    tick();
    a_raw = 1'b0; b_raw = 1'b0;
    tick();
    tick();
    vectors++;
    if (gc !== 8'(exp_glitch)) begin
      miscompares++;
      $display("FAIL dual_pre_abort got=%0d exp=%0d", gc, exp_glitch);
    end
    tick();
    exp_glitch += 2;
    vectors++;
    if (gc !== 8'(exp_glitch) || {a, b, ar, br} !== 4'b0000) begin
      miscompares++;
      $display("FAIL dual_abort got cnt=%0d lv=%b exp cnt=%0d lv=0000", gc, {a, b, ar, br}, exp_glitch);
    end
  endtask

  task automatic test_saturation();
    while (exp_glitch + 2 <= 254) begin
      bounce(1'b1, 1'b1, 1'b0);
      exp_glitch += 2;
    end
    if (exp_glitch < 254) begin
      bounce(1'b1, 1'b0, 1'b0);
      exp_glitch += 1;
    end
    vectors++;
    if (gc !== 8'(exp_glitch)) begin
      miscompares++;
      $display("FAIL sat_preload got=%0d exp=%0d", gc, exp_glitch);
    end
    for (int r = 0; r < 2; r++) begin
      bounce(1'b1, 1'b1, 1'b0);
      exp_glitch = (exp_glitch + 2 > 255) ? 255 : exp_glitch + 2;
      vectors++;
      if (gc !== 8'(exp_glitch)) begin
        miscompares++;
        $display("FAIL sat_dual%0d got=%0d exp=%0d", r, gc, exp_glitch);
      end
    end
  endtask

  task automatic test_clear();
    bounce(1'b1, 1'b1, 1'b1);
    exp_glitch = 0;
    vectors++;
    if (gc !== 8'(exp_glitch)) begin
      miscompares++;
      $display("FAIL clear_with_abort got=%0d exp=%0d", gc, exp_glitch);
    end
    bounce(1'b0, 1'b1, 1'b0);
    exp_glitch = 1;
    vectors++;
    if (gc !== 8'(exp_glitch)) begin
      miscompares++;
      $display("FAIL count_after_clear got=%0d exp=%0d", gc, exp_glitch);
    end
  endtask

  task automatic test_midop_reset();
    logic exp_lvl, exp_rise;
    a_raw = 1'b1;
    for (int i = 1; i <= 8; i++) tick();
    vectors++;
    if (a !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_pre_high got=%b exp=1", a);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_glitch = 0;
    vectors++;
    if ({a, ar} !== 2'b00 || gc !== 8'(exp_glitch)) begin
      miscompares++;
      $display("FAIL midop_reset got a/rise=%b cnt=%0d exp a/rise=00 cnt=%0d", {a, ar}, gc, exp_glitch);
    end
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp_lvl  = (i >= 6);
      exp_rise = (i == 6);
      vectors++;
      if ({a, ar} !== {exp_lvl, exp_rise}) begin
        miscompares++;
        $display("FAIL midop_requal_edge%0d got=%b exp=%b", i, {a, ar}, {exp_lvl, exp_rise});
      end
    end
    a_raw = 1'b0;
    for (int i = 1; i <= 8; i++) tick();
  endtask

  task automatic test_db1();
    logic exp_lvl, exp_rise;
    c_raw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      exp_lvl  = (i >= 4);
      exp_rise = (i == 4);
      vectors++;
      if ({a6, ar6} !== {exp_lvl, exp_rise}) begin
        miscompares++;
        $display("FAIL db1_rise_edge%0d got=%b exp=%b", i, {a6, ar6}, {exp_lvl, exp_rise});
      end
    end
    c_raw = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp_lvl = (i < 4);
      vectors++;
      if ({a6, ar6} !== {exp_lvl, 1'b0}) begin
        miscompares++;
        $display("FAIL db1_fall_edge%0d got=%b exp=%b", i, {a6, ar6}, {exp_lvl, 1'b0});
      end
    end
    // A single-cycle raw pulse still qualifies when DB_CYCLES is 1.
    for (int k = 1; k <= 6; k++) begin
      c_raw = (k == 1);
      tick();
      exp_lvl  = (k == 4);
      exp_rise = (k == 4);
      vectors++;
      if ({a6, ar6} !== {exp_lvl, exp_rise}) begin
        miscompares++;
        $display("FAIL db1_pulse_edge%0d got=%b exp=%b", k, {a6, ar6}, {exp_lvl, exp_rise});
      end
    end
    vectors++;
    if ({b6, br6, gc6} !== 10'd0) begin
      miscompares++;
      $display("FAIL db1_quiet got=%h exp=0", {b6, br6, gc6});
    end
  endtask

  initial begin
    test_reset();
    test_clean_a();
    test_bounce();
    test_simultaneous();
    test_saturation();
    test_clear();
    test_midop_reset();
    test_db1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached exp=summary before limit");
    $fatal(1, "watchdog");
  end

endmodule
